morse_letter_decoder: RTL and testbench

Parametrised Morse front-end that converts a debounced key level into complete characters. It times each press against a tick time-base, classifies it as dot or dash, and accumulates up to MAX_LEN symbols. An inter-letter gap closes the letter, which is looked up to a 6-bit character code and offered on a one-entry valid/ready output register. It sits between the button debouncer and the seven-segment/display or UART consumer, and replaces the fixed 5-symbol dot/dash counter path.

---
 rtl/morse_pkg.sv | 72 +++++++
 rtl/morse_lut.sv | 43 ++++
 rtl/morse_letter_decoder.sv | 161 ++++++++++++++++
 tb/tb_morse_letter_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and Morse pattern tables for the letter decoder.
// The digit table exists only when MORSE_DIGITS_EN is defined.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP
    } state_t;

    localparam logic [5:0] CODE_A       = 6'd0;
    localparam logic [5:0] CODE_DIGIT0  = 6'd26;
    localparam logic [5:0] CODE_INVALID = 6'd63;

    // One Morse pattern: symbol count plus symbols in entry order (bit0 first, 1 = dash).
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] bits;
    } pattern_t;

    localparam pattern_t LETTER_PAT [26] = '{
        '{3'd2, 5'b00010},  // A .-
        '{3'd4, 5'b00001},  // B -...
        '{3'd4, 5'b00101},  // C -.-.
        '{3'd3, 5'b00001},  // D -..
        '{3'd1, 5'b00000},  // E .
        '{3'd4, 5'b00100},  // F ..-.
        '{3'd3, 5'b00011},  // G --.
        '{3'd4, 5'b00000},  // H ....
        '{3'd2, 5'b00000},  // I ..
        '{3'd4, 5'b01110},  // J .---
        '{3'd3, 5'b00101},  // K -.-
        '{3'd4, 5'b00010},  // L .-..
        '{3'd2, 5'b00011},  // M --
        '{3'd2, 5'b00001},  // N -.
        '{3'd3, 5'b00111},  // O ---
        '{3'd4, 5'b00110},  // P .--.
        '{3'd4, 5'b01011},  // Q --.-
        '{3'd3, 5'b00010},  // R .-.
        '{3'd3, 5'b00000},  // S ...
        '{3'd1, 5'b00001},  // T -
        '{3'd3, 5'b00100},  // U ..-
        '{3'd4, 5'b01000},  // V ...-
        '{3'd3, 5'b00110},  // W .--
        '{3'd4, 5'b01001},  // X -..-
        '{3'd4, 5'b01101},  // Y -.--
        '{3'd4, 5'b00011}   // Z --..
    };

`ifdef MORSE_DIGITS_EN
    localparam pattern_t DIGIT_PAT [10] = '{
        '{3'd5, 5'b11111},  // 0 -----
        '{3'd5, 5'b11110},  // 1 .----
        '{3'd5, 5'b11100},  // 2 ..---
        '{3'd5, 5'b11000},  // 3 ...--
        '{3'd5, 5'b10000},  // 4 ....-
        '{3'd5, 5'b00000},  // 5 .....
        '{3'd5, 5'b00001},  // 6 -....
        '{3'd5, 5'b00011},  // 7 --...
        '{3'd5, 5'b00111},  // 8 ---..
        '{3'd5, 5'b01111}   // 9 ----.
    };
`endif

    function automatic logic pattern_match(input pattern_t p, input logic [3:0] count,
                                           input logic [4:0] bits);
        logic [4:0] mask;
        mask = 5'((6'd1 << p.len) - 6'd1);
        return (count == {1'b0, p.len}) && ((bits & mask) == p.bits);
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational lookup from a captured symbol pattern to a 6-bit character code.
// Digit patterns decode only when MORSE_DIGITS_EN is defined.
module morse_lut
    import morse_pkg::*;
#(
    parameter int MAX_LEN = 5,
    localparam int SC_W = $clog2(MAX_LEN + 1)
) (
    input  logic [SC_W-1:0]    sym_count,
    input  logic [MAX_LEN-1:0] sym_bits,
    output logic [5:0]         code
);

    logic [4:0] bits5;
    logic [3:0] count4;

    // Table patterns are at most five symbols long, so only the first five matter.
    if (MAX_LEN >= 5) begin : g_trunc
        assign bits5 = sym_bits[4:0];
    end else begin : g_pad
        assign bits5 = 5'(sym_bits);
    end

    assign count4 = 4'(sym_count);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        code = CODE_INVALID;
        for (int i = 0; i < 26; i++) begin
            if (pattern_match(LETTER_PAT[i], count4, bits5)) begin
                code = CODE_A + 6'(i);
            end
        end
`ifdef MORSE_DIGITS_EN
        for (int i = 0; i < 10; i++) begin
            if (pattern_match(DIGIT_PAT[i], count4, bits5)) begin
                code = CODE_DIGIT0 + 6'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/morse_letter_decoder.sv
// Times key presses against a tick strobe, accumulates dot/dash symbols and emits
// decoded characters through a one-entry valid/ready register. Digits need MORSE_DIGITS_EN.
module morse_letter_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX_TICKS = 3,
    parameter int GAP_TICKS     = 5,
    parameter int MAX_LEN       = 5,
    parameter int CNT_W         = 8,
    localparam int SC_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               b,
    output logic [MAX_LEN-1:0] sym_bits,
    output logic [SC_W-1:0]    sym_count,
    output logic [5:0]         letter_code,
    output logic               letter_valid,
    input  logic               letter_ready,
    output logic               overflow,
    output logic               drop
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_TICKS);
    localparam logic [SC_W-1:0]  SYM_LIMIT = SC_W'(MAX_LEN);
    localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);

    state_t           state, next_state;
    logic             b_q;
    logic             rise, fall;
    logic [CNT_W-1:0] press_cnt, gap_cnt;
    logic [CNT_W-1:0] press_cnt_d, gap_cnt_d;
    logic [CNT_W-1:0] press_inc, gap_inc, fresh_cnt;
    logic             gap_done, dash;
    logic             capture, complete, load;
    logic [5:0]       lut_code, final_code;

    assign rise = b & ~b_q;
    assign fall = ~b & b_q;

    assign press_inc = (press_cnt == CNT_SAT) ? press_cnt : press_cnt + CNT_ONE;
    assign gap_inc   = (gap_cnt == CNT_SAT) ? gap_cnt : gap_cnt + CNT_ONE;
    // A tick on the edge cycle already counts toward the state being entered.
    assign fresh_cnt = tick ? CNT_ONE : '0;
    assign gap_done  = tick && (gap_inc >= GAP_LIMIT);
    assign dash      = press_cnt >= DOT_LIMIT;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            b_q   <= 1'b0;
        end else begin
            state <= next_state;
            b_q   <= b;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rise) next_state = PRESS;
            PRESS:   if (fall) next_state = GAP;
            GAP: begin
                if (rise)          next_state = PRESS;
                else if (gap_done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        press_cnt_d = '0;
        gap_cnt_d   = '0;
        capture     = 1'b0;
        complete    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) press_cnt_d = fresh_cnt;
            end
            PRESS: begin
                if (fall) begin
                    capture   = 1'b1;
                    gap_cnt_d = fresh_cnt;
                end else begin
                    press_cnt_d = tick ? press_inc : press_cnt;
                end
            end
            GAP: begin
                // A rise on the closing tick keeps the letter open.
                if (rise) begin
                    press_cnt_d = fresh_cnt;
                end else if (gap_done) begin
                    complete = 1'b1;
                end else begin
                    gap_cnt_d = tick ? gap_inc : gap_cnt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            press_cnt <= press_cnt_d;
            gap_cnt   <= gap_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_bits  <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
        end else if (complete) begin
            sym_bits  <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
        end else if (capture) begin
            if (sym_count < SYM_LIMIT) begin
                sym_bits  <= sym_bits | (MAX_LEN'(dash) << sym_count);
                sym_count <= sym_count + SC_ONE;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

    morse_lut #(.MAX_LEN(MAX_LEN)) u_lut (
        .sym_count (sym_count),
        .sym_bits  (sym_bits),
        .code      (lut_code)
    );

    assign final_code = overflow ? CODE_INVALID : lut_code;
    assign load       = complete && (!letter_valid || letter_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            letter_code  <= '0;
            letter_valid <= 1'b0;
            drop         <= 1'b0;
        end else begin
            drop <= complete && letter_valid && !letter_ready;
            if (load) begin
                letter_code  <= final_code;
                letter_valid <= 1'b1;
            end else if (letter_ready) begin
                letter_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Scoreboard bench for morse_letter_decoder: stimulus queues expected codes, a monitor
// pops them on each handshake. Expects the digit code only when MORSE_DIGITS_EN is defined.
module tb_morse_letter_decoder;

    localparam int MAX_LEN = 5;
    localparam int SC_W    = 3;

`ifdef MORSE_DIGITS_EN
    localparam int EXP_ZERO = 26;
`else
    localparam int EXP_ZERO = 63;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               tick;
    logic               b;
    logic               letter_ready;
    logic [MAX_LEN-1:0] sym_bits;
    logic [SC_W-1:0]    sym_count;
    logic [5:0]         letter_code;
    logic               letter_valid;
    logic               overflow;
    logic               drop;

    int checks    = 0;
    int failures  = 0;
    int drop_seen = 0;
    int phase     = 0;
    int exp_q[$];

    morse_letter_decoder #(
        .DOT_MAX_TICKS (3),
        .GAP_TICKS     (5),
        .MAX_LEN       (MAX_LEN),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .b            (b),
        .sym_bits     (sym_bits),
        .sym_count    (sym_count),
        .letter_code  (letter_code),
        .letter_valid (letter_valid),
        .letter_ready (letter_ready),
        .overflow     (overflow),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Monitor: every handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && letter_valid && letter_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_letter: actual=%0d required=none", letter_code);
            end else begin
                check("letter_code", 32'(letter_code), 32'(exp_q.pop_front()));
            end
        end
        if (!reset && drop) drop_seen++;
    end

    // One clock; tick is high on every fourth cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 4;
        tick  = (phase == 0);
    endtask

    task automatic align();
        while (phase != 1) cycle();
    endtask

    // Advance until n tick cycles have been presented; ends inside the n-th tick cycle.
    task automatic seek_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            cycle();
            if (tick) seen++;
        end
    endtask

    task automatic run_ticks(input int n);
        seek_ticks(n);
        cycle();
    endtask

    task automatic symbol(input int down, input int up);
        align();
        b = 1'b1;
        run_ticks(down);
        b = 1'b0;
        run_ticks(up);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        b = 1'b0;
        letter_ready = 1'b1;
        repeat (3) cycle();
        check("rst_sym_bits", 32'(sym_bits), 0);
        check("rst_sym_count", 32'(sym_count), 0);
        check("rst_code", 32'(letter_code), 0);
        check("rst_valid", 32'(letter_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop", 32'(drop), 0);
        reset = 1'b0;
        align();

        // E: valid appears one cycle after the fifth gap tick
        exp_q.push_back(4);
        symbol(1, 4);
        check("e_valid_early", 32'(letter_valid), 0);
        check("e_count", 32'(sym_count), 1);
        run_ticks(1);
        check("e_valid", 32'(letter_valid), 1);
        check("e_count_clr", 32'(sym_count), 0);
        run_ticks(2);

        // C: dash dot dash dot
        exp_q.push_back(2);
        symbol(5, 1); symbol(1, 1); symbol(5, 1); symbol(1, 1);
        check("c_bits", 32'(sym_bits), 32'h5);
        check("c_count", 32'(sym_count), 4);
        run_ticks(6);

        // A via thresholds: 2 ticks = dot, 3 ticks = dash, 4-tick gap keeps letter open
        exp_q.push_back(0);
        symbol(2, 4);
        symbol(3, 6);

        // A via rise on the closing tick; that tick counts toward the new press
        exp_q.push_back(0);
        symbol(1, 0);
        b = 1'b0;
        seek_ticks(5);
        b = 1'b1;
        run_ticks(2);
        b = 1'b0;
        run_ticks(6);

        // Overflow: six dots
        exp_q.push_back(63);
        repeat (5) symbol(1, 1);
        check("ovf_before", 32'(overflow), 0);
        check("ovf_count5", 32'(sym_count), 5);
        symbol(1, 1);
        check("ovf_set", 32'(overflow), 1);
        check("ovf_count_hold", 32'(sym_count), 5);
        run_ticks(6);
        check("ovf_cleared", 32'(overflow), 0);
        check("ovf_count_clr", 32'(sym_count), 0);

        // Backpressure: E held, T dropped
        letter_ready = 1'b0;
        exp_q.push_back(4);
        symbol(1, 5);
        symbol(5, 5);
        cycle();
        check("bp_drop_once", 32'(drop_seen), 1);
        check("bp_valid_held", 32'(letter_valid), 1);
        check("bp_code_held", 32'(letter_code), 4);
        letter_ready = 1'b1;
        cycle();
        cycle();
        check("bp_valid_clr", 32'(letter_valid), 0);
        check("bp_queue_empty", 32'(exp_q.size()), 0);

        // Ready pulsed on the completion cycle of T while E is pending
        letter_ready = 1'b0;
        exp_q.push_back(4);
        exp_q.push_back(19);
        symbol(1, 5);
        align();
        b = 1'b1;
        run_ticks(5);
        b = 1'b0;
        seek_ticks(5);
        letter_ready = 1'b1;
        cycle();
        letter_ready = 1'b0;
        check("swap_valid", 32'(letter_valid), 1);
        check("swap_code", 32'(letter_code), 19);
        cycle();
        check("swap_no_drop", 32'(drop_seen), 1);
        letter_ready = 1'b1;
        cycle();
        cycle();
        check("swap_valid_clr", 32'(letter_valid), 0);

        // Reset mid-press with a pending letter and two symbols captured
        letter_ready = 1'b0;
        symbol(1, 5);
        symbol(1, 1);
        symbol(5, 1);
        b = 1'b1;
        cycle();
        cycle();
        check("pre_rst_count", 32'(sym_count), 2);
        check("pre_rst_valid", 32'(letter_valid), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_sym_bits", 32'(sym_bits), 0);
        check("mid_rst_sym_count", 32'(sym_count), 0);
        check("mid_rst_code", 32'(letter_code), 0);
        check("mid_rst_valid", 32'(letter_valid), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        check("mid_rst_drop", 32'(drop), 0);
        cycle();
        b = 1'b0;
        cycle();
        reset = 1'b0;
        letter_ready = 1'b1;
        check("rst_no_drop", 32'(drop_seen), 1);

        // Five dashes: digit 0 when enabled, invalid otherwise
        exp_q.push_back(EXP_ZERO);
        repeat (4) symbol(5, 1);
        symbol(5, 6);

        repeat (8) cycle();
        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
